// File: rtl/control_unit.sv
// Multicycle CPU main controller: a Moore FSM that advances one state per clock and decodes OPCODE/FUNCT into datapath enables and mux selects.
// Outputs depend on the current state, plus Zero in BEQ and FUNCT in R_EX. Memory latency is absorbed by a MEM_WAIT cycle counter; there is no other backpressure.
module control_unit #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       ABWrite,
  output logic       ALUOutWrite,
  output logic       MDRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [4:0] state_out
);

  typedef enum logic [4:0] {
    S_RESET    = 5'd0,
    S_FETCH    = 5'd1,
    S_FETCH_W  = 5'd2,
    S_FETCH_LD = 5'd3,
    S_DECODE   = 5'd4,
    S_R_EX     = 5'd5,
    S_R_WB     = 5'd6,
    S_ADDI_EX  = 5'd7,
    S_ADDI_WB  = 5'd8,
    S_ADDR     = 5'd9,
    S_LW_RD    = 5'd10,
    S_LW_W     = 5'd11,
    S_LW_LD    = 5'd12,
    S_LW_WB    = 5'd13,
    S_SW_WR    = 5'd14,
    S_BEQ      = 5'd15,
    S_JUMP     = 5'd16,
    S_EXC      = 5'd17
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] WAIT_INIT = MEM_WAIT[1:0];
  localparam bit         NO_WAIT   = (MEM_WAIT == 0);

  state_t     state, state_nxt;
  logic [1:0] wait_cnt;
  logic       funct_ok;
  logic [2:0] funct_alu;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_RESET;
      wait_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      // Address-issue states load the latency; wait states count it down.
      case (state)
        S_FETCH, S_LW_RD:  wait_cnt <= WAIT_INIT;
        S_FETCH_W, S_LW_W: wait_cnt <= wait_cnt - 2'd1;
        default:           wait_cnt <= wait_cnt;
      endcase
    end
  end

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (FUNCT)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:    state_nxt = S_FETCH;
      S_FETCH:    state_nxt = NO_WAIT ? S_FETCH_LD : S_FETCH_W;
      S_FETCH_W:  state_nxt = (wait_cnt <= 2'd1) ? S_FETCH_LD : S_FETCH_W;
      S_FETCH_LD: state_nxt = S_DECODE;
      S_DECODE: begin
        case (OPCODE)
          OP_RTYPE:     state_nxt = S_R_EX;
          OP_ADDI:      state_nxt = S_ADDI_EX;
          OP_LW, OP_SW: state_nxt = S_ADDR;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JUMP:      state_nxt = S_JUMP;
          default:      state_nxt = S_EXC;
        endcase
      end
      S_R_EX:     state_nxt = funct_ok ? S_R_WB : S_EXC;
      S_R_WB:     state_nxt = S_FETCH;
      S_ADDI_EX:  state_nxt = S_ADDI_WB;
      S_ADDI_WB:  state_nxt = S_FETCH;
      S_ADDR:     state_nxt = (OPCODE == OP_LW) ? S_LW_RD : S_SW_WR;
      S_LW_RD:    state_nxt = NO_WAIT ? S_LW_LD : S_LW_W;
      S_LW_W:     state_nxt = (wait_cnt <= 2'd1) ? S_LW_LD : S_LW_W;
      S_LW_LD:    state_nxt = S_LW_WB;
      S_LW_WB:    state_nxt = S_FETCH;
      S_SW_WR:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      S_EXC:      state_nxt = S_FETCH;
      default:    state_nxt = S_RESET;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    IorD        = 1'b0;
    ABWrite     = 1'b0;
    ALUOutWrite = 1'b0;
    MDRWrite    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_ADD;
    PCSource    = 2'b00;
    case (state)
      S_FETCH_LD: begin
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      S_DECODE: begin
        ABWrite     = 1'b1;
        ALUOutWrite = 1'b1;
        ALUSrcB     = 2'b11;
      end
      S_R_EX: begin
        // An illegal FUNCT must not clobber ALUOut on its way to EXC.
        ALUSrcA     = 1'b1;
        ALUOutWrite = funct_ok;
        ALUOp       = funct_alu;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDI_EX, S_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALUOutWrite = 1'b1;
      end
      S_ADDI_WB: RegWrite = 1'b1;
      S_LW_RD, S_LW_W: IorD = 1'b1;
      S_LW_LD: begin
        IorD     = 1'b1;
        MDRWrite = 1'b1;
      end
      S_LW_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_SW_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = 2'b01;
        PCWrite  = Zero;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      S_EXC: begin
        PCSource = 2'b11;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_out = state;

endmodule
